// File: rtl/gpu_pkg.sv
// Shared constants for the GPU display path: line-buffer geometry,
// default video timing and bank encoding.
package gpu_pkg;

  localparam int RAM_A_BITS = 8;
  localparam int RAM_D_BITS = 8;

  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 192;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 21;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/video_timing.sv
// Horizontal/vertical raster counters with active/sync decode and a
// line-start strobe. Counters sit at zero while reset or disabled.
module video_timing #(
  parameter int H_ACTIVE = gpu_pkg::DEF_H_ACTIVE,
  parameter int H_FP     = gpu_pkg::DEF_H_FP,
  parameter int H_SYNC   = gpu_pkg::DEF_H_SYNC,
  parameter int H_BP     = gpu_pkg::DEF_H_BP,
  parameter int V_ACTIVE = gpu_pkg::DEF_V_ACTIVE,
  parameter int V_FP     = gpu_pkg::DEF_V_FP,
  parameter int V_SYNC   = gpu_pkg::DEF_V_SYNC,
  parameter int V_BP     = gpu_pkg::DEF_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          active_o,
  output logic          hsync_act_o,
  output logic          vsync_act_o,
  output logic          line_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o      = h_q;
  assign v_cnt_o      = v_q;
  assign active_o     = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
  assign hsync_act_o  = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_act_o  = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign line_start_o = en_i && !rst_i && (h_q == '0);

endmodule

// File: rtl/line_scanout.sv
// Display scan-out: reads the ping-pong line buffers, emits registered
// video, requests next-line fills and flags late fills as underruns.
module line_scanout
  import gpu_pkg::*;
#(
  parameter int   RAM_A_BITS = gpu_pkg::RAM_A_BITS,
  parameter int   RAM_D_BITS = gpu_pkg::RAM_D_BITS,
  parameter int   H_ACTIVE   = gpu_pkg::DEF_H_ACTIVE,
  parameter int   H_FP       = gpu_pkg::DEF_H_FP,
  parameter int   H_SYNC     = gpu_pkg::DEF_H_SYNC,
  parameter int   H_BP       = gpu_pkg::DEF_H_BP,
  parameter int   V_ACTIVE   = gpu_pkg::DEF_V_ACTIVE,
  parameter int   V_FP       = gpu_pkg::DEF_V_FP,
  parameter int   V_SYNC     = gpu_pkg::DEF_V_SYNC,
  parameter int   V_BP       = gpu_pkg::DEF_V_BP,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable_i,
  output logic [RAM_A_BITS-1:0] buf_a_a_o,
  output logic                  buf_a_cen_o,
  input  logic [RAM_D_BITS-1:0] buf_a_r_q_i,
  input  logic [RAM_D_BITS-1:0] buf_a_g_q_i,
  input  logic [RAM_D_BITS-1:0] buf_a_b_q_i,
  output logic [RAM_A_BITS-1:0] buf_b_a_o,
  output logic                  buf_b_cen_o,
  input  logic [RAM_D_BITS-1:0] buf_b_r_q_i,
  input  logic [RAM_D_BITS-1:0] buf_b_g_q_i,
  input  logic [RAM_D_BITS-1:0] buf_b_b_q_i,
  output logic                  fill_req_o,
  output logic [7:0]            fill_line_o,
  output logic                  fill_bank_o,
  input  logic                  fill_done_i,
  output logic [RAM_D_BITS-1:0] r_o,
  output logic [RAM_D_BITS-1:0] g_o,
  output logic [RAM_D_BITS-1:0] b_o,
  output logic                  de_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  underrun_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic          run;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, hsync_act, vsync_act, line_start;

  assign run = enable_i && !wb_rst_i;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .en_i        (enable_i),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .hsync_act_o (hsync_act),
    .vsync_act_o (vsync_act),
    .line_start_o(line_start)
  );

  always_comb begin
    buf_a_cen_o = 1'b1;
    buf_b_cen_o = 1'b1;
    buf_a_a_o   = '0;
    buf_b_a_o   = '0;
    if (run && active) begin
      if (v_cnt[0] == BANK_B) begin
        buf_b_cen_o = 1'b0;
        buf_b_a_o   = RAM_A_BITS'(h_cnt);
      end else begin
        buf_a_cen_o = 1'b0;
        buf_a_a_o   = RAM_A_BITS'(h_cnt);
      end
    end
  end

  // Next displayed line: wraps to line 0 from the last vertical-blank line.
  logic          last_line, fill_req;
  logic [VW-1:0] v_next;

  assign last_line = (v_cnt == VW'(V_TOTAL - 1));
  assign v_next    = last_line ? '0 : v_cnt + 1'b1;
  assign fill_req  = line_start && (last_line || (v_cnt < VW'(V_ACTIVE - 1)));

  assign fill_req_o  = fill_req;
  assign fill_line_o = fill_req ? 8'(v_next) : 8'h00;
  assign fill_bank_o = fill_req && v_next[0];

  logic pending_q, pending_d;
  logic line_blank_q, line_blank_d;
  logic underrun_q, underrun_d;
  logic de_q, de_d;
  logic bank_q, bank_d;
  logic out_blank_q, out_blank_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic under_evt, blank_now;

  // The check looks at the pending flag from before this cycle's request.
  assign under_evt = run && (h_cnt == '0) && (v_cnt < VW'(V_ACTIVE))
                     && pending_q && !fill_done_i;
  assign blank_now = line_start ? under_evt : line_blank_q;

  always_comb begin
    pending_d    = pending_q;
    line_blank_d = 1'b0;
    de_d         = 1'b0;
    bank_d       = 1'b0;
    out_blank_d  = 1'b0;
    hsync_d      = ~HSYNC_POL;
    vsync_d      = ~VSYNC_POL;
    underrun_d   = underrun_q || under_evt;
    if (!run) begin
      pending_d = 1'b0;
    end else begin
      if (fill_req)         pending_d = 1'b1;
      else if (fill_done_i) pending_d = 1'b0;
      line_blank_d = blank_now;
      de_d         = active;
      bank_d       = v_cnt[0];
      out_blank_d  = blank_now;
      hsync_d      = hsync_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_d      = vsync_act ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pending_q    <= 1'b0;
      line_blank_q <= 1'b0;
      underrun_q   <= 1'b0;
      de_q         <= 1'b0;
      bank_q       <= 1'b0;
      out_blank_q  <= 1'b0;
      hsync_q      <= ~HSYNC_POL;
      vsync_q      <= ~VSYNC_POL;
    end else begin
      pending_q    <= pending_d;
      line_blank_q <= line_blank_d;
      underrun_q   <= underrun_d;
      de_q         <= de_d;
      bank_q       <= bank_d;
      out_blank_q  <= out_blank_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  // SRAM q is already one cycle behind the address, so colour is muxed live.
  always_comb begin
    r_o = '0;
    g_o = '0;
    b_o = '0;
    if (de_q && !out_blank_q) begin
      if (bank_q == BANK_B) begin
        r_o = buf_b_r_q_i;
        g_o = buf_b_g_q_i;
        b_o = buf_b_b_q_i;
      end else begin
        r_o = buf_a_r_q_i;
        g_o = buf_a_g_q_i;
        b_o = buf_a_b_q_i;
      end
    end
  end

  assign de_o       = de_q;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_line_scanout.sv
// Directed bench for line_scanout on a 14x7 raster: timing, bank reads,
// fill requests, underrun blanking and mid-line reset.
module tb_line_scanout;

  logic       clk = 1'b0;
  logic       rst, en, fill_done;
  logic [7:0] a_addr, b_addr;
  logic       a_cen, b_cen;
  logic [7:0] qa, qb;
  logic       fill_req, fill_bank;
  logic [7:0] fill_line;
  logic [7:0] r, g, b;
  logic       de, hs, vs, und;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_at  = -1;
  int ph, pv, pfr;

  always #5 clk = ~clk;

  // Line-buffer models: one-cycle read latency, distinct pattern per bank/plane.
  always @(posedge clk) begin
    if (!a_cen) qa <= a_addr;
    if (!b_cen) qb <= b_addr;
  end

  line_scanout #(
    .RAM_A_BITS(8), .RAM_D_BITS(8),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .enable_i   (en),
    .buf_a_a_o  (a_addr),
    .buf_a_cen_o(a_cen),
    .buf_a_r_q_i(qa),
    .buf_a_g_q_i(qa | 8'h40),
    .buf_a_b_q_i(qa | 8'h20),
    .buf_b_a_o  (b_addr),
    .buf_b_cen_o(b_cen),
    .buf_b_r_q_i(qb | 8'h80),
    .buf_b_g_q_i(qb | 8'hC0),
    .buf_b_b_q_i(qb | 8'hA0),
    .fill_req_o (fill_req),
    .fill_line_o(fill_line),
    .fill_bank_o(fill_bank),
    .fill_done_i(fill_done),
    .r_o        (r),
    .g_o        (g),
    .b_o        (b),
    .de_o       (de),
    .hsync_o    (hs),
    .vsync_o    (vs),
    .underrun_o (und)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, " de"}, de, 0);
    check({p, " hsync"}, hs, 1);
    check({p, " vsync"}, vs, 1);
    check({p, " r"}, r, 0);
    check({p, " g"}, g, 0);
    check({p, " b"}, b, 0);
    check({p, " cen_a"}, a_cen, 1);
    check({p, " cen_b"}, b_cen, 1);
    check({p, " addr_a"}, a_addr, 0);
    check({p, " addr_b"}, b_addr, 0);
    check({p, " fill_req"}, fill_req, 0);
    check({p, " fill_line"}, fill_line, 0);
    check({p, " fill_bank"}, fill_bank, 0);
    check({p, " underrun"}, und, 0);
  endtask

  // rel counts cycles since reset release; frame 1 acks line 1 at the next
  // line start, frame 2 never acks the line-2 request.
  task automatic step(input int rel, input int fr_off, input bit first);
    int h, v, fr, base, line_e;
    bit act, pact, req_e, blank;
    string p;
    h  = rel % 14;
    v  = (rel / 14) % 7;
    fr = fr_off + rel / 98;
    p  = $sformatf("rel%0d f%0d v%0d h%0d", rel, fr, v, h);
    fill_done = (ack_at == rel);
    #1;
    act = (h < 8) && (v < 4);
    check({p, " cen_a"}, a_cen, !(act && v % 2 == 0));
    check({p, " cen_b"}, b_cen, !(act && v % 2 == 1));
    check({p, " addr_a"}, a_addr, (act && v % 2 == 0) ? h : 0);
    check({p, " addr_b"}, b_addr, (act && v % 2 == 1) ? h : 0);
    req_e  = (h == 0) && (v < 3 || v == 6);
    line_e = req_e ? ((v == 6) ? 0 : v + 1) : 0;
    check({p, " fill_req"}, fill_req, req_e);
    check({p, " fill_line"}, fill_line, line_e);
    check({p, " fill_bank"}, fill_bank, line_e % 2);
    if (first) begin
      check({p, " de"}, de, 0);
      check({p, " hsync"}, hs, 1);
      check({p, " vsync"}, vs, 1);
      check({p, " r"}, r, 0);
    end else begin
      pact  = (ph < 8) && (pv < 4);
      blank = (pfr == 2) && (pv == 2);
      base  = (pv % 2 == 1) ? 8'h80 : 8'h00;
      check({p, " de"}, de, pact);
      check({p, " hsync"}, hs, !(ph == 10 || ph == 11));
      check({p, " vsync"}, vs, !(pv == 5));
      check({p, " r"}, r, (pact && !blank) ? (base | ph) : 0);
      check({p, " g"}, g, (pact && !blank) ? (base | 8'h40 | ph) : 0);
      check({p, " b"}, b, (pact && !blank) ? (base | 8'h20 | ph) : 0);
    end
    // Underrun registers at the end of frame 2, line 2, h=0: rel 2*98+2*14.
    check({p, " underrun"}, und, (fr_off == 0) && (rel >= 225));
    if (fill_req === 1'b1) begin
      if (fr == 1 && v == 0)      ack_at = rel + 14;
      else if (fr == 2 && v == 1) ack_at = -1;
      else                        ack_at = rel + 1;
    end
    ph  = h;
    pv  = v;
    pfr = fr;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    fill_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("init");

    rst = 1'b0;
    for (int rel = 0; rel <= 327; rel++) begin
      step(rel, 0, rel == 0);
      if (rel < 327) begin
        @(negedge clk);
        #1;
      end
    end

    // rel 327 is frame 3, v=2, h=5: reset mid-line.
    rst       = 1'b1;
    fill_done = 1'b0;
    @(negedge clk);
    #1;
    check_reset("midrst");

    rst    = 1'b0;
    ack_at = -1;
    for (int rel = 0; rel <= 40; rel++) begin
      step(rel, 4, rel == 0);
      @(negedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
